// File: rtl/board_rle_encoder_if.sv
// Pixel-in / byte-out handshake bundle for the board run-length encoder.
interface board_rle_encoder_if;
  logic       pixel_in;
  logic       pixel_first;
  logic       pixel_valid;
  logic       pixel_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  // Environment side: drives pixels, accepts bytes
  modport master (
    output pixel_in, pixel_first, pixel_valid, byte_ready,
    input  pixel_ready, byte_out, byte_valid
  );

  // Encoder side: accepts pixels, drives bytes
  modport slave (
    input  pixel_in, pixel_first, pixel_valid, byte_ready,
    output pixel_ready, byte_out, byte_valid
  );
endinterface

// File: rtl/board_rle_encoder.sv
// Captures one Game-of-Life frame from the pixel stream and run-length
// encodes it as {value, run-1} bytes for the HPS board upload path.
module board_rle_encoder #(
  parameter int unsigned FRAME_PIXELS = 2073600,
  parameter int unsigned CNT_W        = 22
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  board_rle_encoder_if.slave bus,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   byte_count
);
  localparam int unsigned      RUN_W    = 7;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(127);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_FLUSH,
    S_DRAIN
  } state_t;

  state_t             state, state_d;
  logic               cur_val, cur_val_d;
  logic [RUN_W-1:0]   run, run_d;
  logic [CNT_W-1:0]   pix_cnt, pix_cnt_d;
  logic [7:0]         byte_q, byte_d;
  logic               byte_valid_q, byte_valid_d;
  logic [CNT_W-1:0]   byte_count_d;
  logic               busy_d, done_d;
  logic               slot_free, byte_cons, pixel_ready_c, pix_acc;

  // Single-entry output slot: free when empty or being drained this cycle
  assign slot_free = !byte_valid_q | bus.byte_ready;
  assign byte_cons = byte_valid_q & bus.byte_ready;

  // Pixels are taken while hunting for frame start, or while capturing with room for a byte
  assign pixel_ready_c   = !abort & ((state == S_ARM) | ((state == S_RUN) & slot_free));
  assign pix_acc         = bus.pixel_valid & pixel_ready_c;
  assign bus.pixel_ready = pixel_ready_c;
  assign bus.byte_out    = byte_q;
  assign bus.byte_valid  = byte_valid_q;

  // Next-state, run tracking and byte emission
  always_comb begin
    state_d      = state;
    cur_val_d    = cur_val;
    run_d        = run;
    pix_cnt_d    = pix_cnt;
    byte_d       = byte_q;
    byte_valid_d = byte_valid_q & !bus.byte_ready;
    byte_count_d = byte_count;
    done_d       = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d      = S_ARM;
          byte_count_d = '0;
          pix_cnt_d    = '0;
          run_d        = '0;
        end
      end
      S_ARM: begin
        if (pix_acc && bus.pixel_first) begin
          cur_val_d = bus.pixel_in;
          run_d     = '0;
          pix_cnt_d = CNT_W'(1);
          state_d   = (FRAME_PIXELS == 1) ? S_FLUSH : S_RUN;
        end
      end
      S_RUN: begin
        if (pix_acc) begin
          pix_cnt_d = pix_cnt + CNT_W'(1);
          if ((bus.pixel_in == cur_val) && (run != RUN_MAX)) begin
            run_d = run + RUN_W'(1);
          end else begin
            byte_d       = {cur_val, run};
            byte_valid_d = 1'b1;
            byte_count_d = byte_count + CNT_W'(1);
            cur_val_d    = bus.pixel_in;
            run_d        = '0;
          end
          if (pix_cnt == LAST_IDX) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (slot_free) begin
          byte_d       = {cur_val, run};
          byte_valid_d = 1'b1;
          byte_count_d = byte_count + CNT_W'(1);
          state_d      = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (byte_cons) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything: drop the pending byte, keep the byte count
    if (abort) begin
      state_d      = S_IDLE;
      byte_valid_d = 1'b0;
      byte_count_d = byte_count;
      done_d       = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cur_val      <= 1'b0;
      run          <= '0;
      pix_cnt      <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_count   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_d;
      cur_val      <= cur_val_d;
      run          <= run_d;
      pix_cnt      <= pix_cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      byte_count   <= byte_count_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end
endmodule

// File: tb/tb_board_rle_encoder.sv
// Bench for board_rle_encoder: four instances with different frame sizes,
// a run-based reference encoder, and directed plus randomized frames.
module tb_board_rle_encoder;
  localparam int unsigned NI = 4;
  localparam int unsigned CW = 22;

  logic clock;
  logic reset;
  logic start_r, abort_r, px_r, pf_r, pv_r, br_r;
  int   act;

  logic          pr_w   [NI];
  logic          bv_w   [NI];
  logic [7:0]    bo_w   [NI];
  logic          busy_w [NI];
  logic          done_w [NI];
  logic [CW-1:0] bc_w   [NI];

  logic          pr_a, bv_a, busy_a, done_a;
  logic [7:0]    bo_a;
  logic [CW-1:0] bc_a;

  // Reference state
  logic       frame_q [$];
  logic [7:0] exp_q   [$];
  logic [7:0] got_q   [$];
  int         exp_cnt;
  int         done_n;
  logic       hold;
  logic [7:0] hold_byte;
  logic       acc;
  logic       in_frame;
  int         stall_left;
  logic       stall_started;
  int         checks;
  int         errors;

  function automatic int frame_len(input int i);
    case (i)
      0:       return 300;
      1:       return 8;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned FP = (g == 0) ? 300 : (g == 1) ? 8 : (g == 2) ? 4 : 1;
    board_rle_encoder_if bus ();
    logic st;
    assign st              = start_r & (act == g);
    assign bus.pixel_in    = px_r;
    assign bus.pixel_first = pf_r;
    assign bus.pixel_valid = pv_r;
    assign bus.byte_ready  = br_r;
    assign pr_w[g]         = bus.pixel_ready;
    assign bv_w[g]         = bus.byte_valid;
    assign bo_w[g]         = bus.byte_out;

    board_rle_encoder #(.FRAME_PIXELS(FP), .CNT_W(CW)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (st),
      .abort      (abort_r),
      .bus        (bus),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .byte_count (bc_w[g])
    );
  end

  always_comb begin
    pr_a   = pr_w[act];
    bv_a   = bv_w[act];
    bo_a   = bo_w[act];
    busy_a = busy_w[act];
    done_a = done_w[act];
    bc_a   = bc_w[act];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (instance %0d, t=%0t)", name, got, want, act, $time);
    end
  endtask

  // Reference encoder: split the frame into maximal runs, then into chunks of at most 128
  task automatic build_model();
    int   i;
    int   len;
    logic v;
    exp_q.delete();
    i = 0;
    while (i < frame_q.size()) begin
      v   = frame_q[i];
      len = 0;
      while (i < frame_q.size() && frame_q[i] == v) begin
        len++;
        i++;
      end
      while (len > 128) begin
        exp_q.push_back({v, 7'd127});
        len -= 128;
      end
      exp_q.push_back({v, 7'(len - 1)});
    end
    exp_cnt = exp_q.size();
  endtask

  // One clock: sample and compare at the falling edge, return just after the rising edge
  task automatic step();
    @(negedge clock);
    acc = pv_r & pr_a;
    if (hold) begin
      chk("hold_valid", 32'(bv_a), 1);
      chk("hold_byte", 32'(bo_a), 32'(hold_byte));
    end
    if (bv_a && !br_r) chk("stall_pixel_ready", 32'(pr_a), 0);
    if (in_frame && !done_a) chk("busy_in_frame", 32'(busy_a), 1);
    if (bv_a && br_r) begin
      got_q.push_back(bo_a);
      if (exp_q.size() == 0) chk("extra_byte_count", got_q.size(), exp_cnt);
      else chk("byte_value", 32'(bo_a), 32'(exp_q.pop_front()));
    end
    if (done_a) begin
      done_n++;
      chk("done_busy", 32'(busy_a), 0);
      chk("done_byte_count", 32'(bc_a), exp_cnt);
      chk("done_all_bytes", got_q.size(), exp_cnt);
      in_frame = 1'b0;
    end
    hold      = bv_a & !br_r & !abort_r;
    hold_byte = bo_a;
    @(posedge clock);
    #1;
  endtask

  task automatic pick_br(input int mode);
    case (mode)
      0: br_r = 1'b1;
      1: br_r = 1'($urandom_range(0, 2) != 0);
      default: begin
        if (!stall_started && bv_a) begin
          stall_started = 1'b1;
          stall_left    = 10;
        end
        if (stall_left > 0) begin
          br_r = 1'b0;
          stall_left--;
        end else begin
          br_r = 1'b1;
        end
      end
    endcase
  endtask

  // Start, optionally feed leading non-first pixels, stream the frame, wait for done
  task automatic encode_frame(input int mode, input int junk);
    int idx;
    int budget;
    build_model();
    got_q.delete();
    done_n        = 0;
    stall_started = 1'b0;
    stall_left    = 0;
    hold          = 1'b0;
    start_r = 1'b1;
    pick_br(mode);
    step();
    start_r = 1'b0;
    chk("busy_after_start", 32'(busy_a), 1);
    in_frame = 1'b1;
    for (int k = 0; k < junk; k++) begin
      pv_r = 1'b1;
      pf_r = 1'b0;
      px_r = 1'($urandom);
      pick_br(mode);
      step();
      chk("junk_accepted", 32'(acc), 1);
    end
    idx    = 0;
    budget = 0;
    while (idx < frame_q.size() && budget < 20000) begin
      pv_r = (mode == 1) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      pf_r = (idx == 0) ? 1'b1 : 1'($urandom_range(0, 7) == 0);
      px_r = frame_q[idx];
      pick_br(mode);
      step();
      budget++;
      if (acc) idx++;
    end
    pv_r = 1'b0;
    pf_r = 1'b0;
    chk("frame_fed", idx, frame_q.size());
    if (mode == 0) chk("throughput_cycles", budget, frame_q.size());
    budget = 0;
    while (done_n == 0 && budget < 2000) begin
      pick_br(mode);
      step();
      budget++;
    end
    chk("done_seen", done_n, 1);
    br_r = 1'b1;
    step();
    step();
    chk("done_single_pulse", done_n, 1);
    chk("idle_busy", 32'(busy_a), 0);
    in_frame = 1'b0;
  endtask

  task automatic make_random_frame(input int n);
    int   style;
    logic v;
    frame_q.delete();
    style = $urandom_range(0, 2);
    v     = 1'($urandom);
    for (int k = 0; k < n; k++) begin
      case (style)
        0:       v = 1'($urandom);
        1:       if ($urandom_range(0, 9) == 0) v = ~v;
        default: if ($urandom_range(0, 199) == 0) v = ~v;
      endcase
      frame_q.push_back(v);
    end
  endtask

  task automatic set_frame(input logic [7:0] bits, input int n);
    frame_q.delete();
    for (int k = 0; k < n; k++) frame_q.push_back(bits[7 - k]);
  endtask

  initial begin
    int idx;
    int budget;
    checks = 0;    errors = 0;
    act = 0;       reset = 1'b1;
    start_r = 0;   abort_r = 0;  px_r = 0;  pf_r = 0;  pv_r = 0;  br_r = 0;
    hold = 0;      in_frame = 0; acc = 0;   done_n = 0; exp_cnt = 0;
    stall_left = 0; stall_started = 0; hold_byte = '0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_byte_valid", 32'(bv_a), 0);
    chk("rst_byte_out", 32'(bo_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_byte_count", 32'(bc_a), 0);
    chk("rst_pixel_ready", 32'(pr_a), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // 300 zero cells: two saturated runs and a 44-cell tail
    act = 0;
    frame_q.delete();
    for (int k = 0; k < 300; k++) frame_q.push_back(1'b0);
    encode_frame(0, 0);
    chk("t1_model_cnt", exp_cnt, 3);
    chk("t1_nbytes", got_q.size(), 3);
    chk("t1_b0", 32'(got_q[0]), 'h7F);
    chk("t1_b1", 32'(got_q[1]), 'h7F);
    chk("t1_b2", 32'(got_q[2]), 'h2B);
    chk("t1_byte_count", 32'(bc_a), 3);

    // Five ones then three zeros
    act = 1;
    set_frame(8'b1111_1000, 8);
    encode_frame(0, 0);
    chk("t2_nbytes", got_q.size(), 2);
    chk("t2_b0", 32'(got_q[0]), 'h84);
    chk("t2_b1", 32'(got_q[1]), 'h02);

    // Alternating cells with a 10-cycle sink stall after the first byte
    act = 2;
    set_frame(8'b1010_0000, 4);
    encode_frame(2, 0);
    chk("t3_nbytes", got_q.size(), 4);
    chk("t3_b0", 32'(got_q[0]), 'h80);
    chk("t3_b1", 32'(got_q[1]), 'h00);
    chk("t3_b2", 32'(got_q[2]), 'h80);
    chk("t3_b3", 32'(got_q[3]), 'h00);

    // Leading pixels without pixel_first are discarded
    set_frame(8'b1111_0000, 4);
    encode_frame(0, 5);
    chk("t4_nbytes", got_q.size(), 1);
    chk("t4_b0", 32'(got_q[0]), 'h83);

    // Abort in RUN with a byte waiting in the slot
    act = 1;
    exp_q.delete(); got_q.delete();
    exp_cnt = 0; done_n = 0; hold = 1'b0;
    set_frame(8'b1100_0000, 3);
    br_r = 1'b0;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    idx = 0; budget = 0;
    while (idx < 3 && budget < 50) begin
      pv_r = 1'b1;
      pf_r = (idx == 0);
      px_r = frame_q[idx];
      step();
      budget++;
      if (acc) idx++;
    end
    pv_r = 1'b0; pf_r = 1'b0;
    chk("abort_pending_valid", 32'(bv_a), 1);
    chk("abort_pending_byte", 32'(bo_a), 'h81);
    chk("abort_pending_count", 32'(bc_a), 1);
    abort_r = 1'b1;
    step();
    abort_r = 1'b0;
    chk("abort_valid_drop", 32'(bv_a), 0);
    chk("abort_busy", 32'(busy_a), 0);
    chk("abort_count_hold", 32'(bc_a), 1);
    br_r = 1'b1;
    repeat (3) step();
    chk("abort_no_done", done_n, 0);
    make_random_frame(8);
    encode_frame(1, 1);

    // Asynchronous reset while draining the final byte
    act = 2;
    set_frame(8'b1111_0000, 4);
    build_model();
    got_q.delete(); done_n = 0; hold = 1'b0;
    br_r = 1'b0;
    start_r = 1'b1;
    step();
    start_r = 1'b0;
    idx = 0; budget = 0;
    while (idx < 4 && budget < 50) begin
      pv_r = 1'b1;
      pf_r = (idx == 0);
      px_r = frame_q[idx];
      step();
      budget++;
      if (acc) idx++;
    end
    pv_r = 1'b0; pf_r = 1'b0;
    budget = 0;
    while (!bv_a && budget < 10) begin
      step();
      budget++;
    end
    chk("drain_valid", 32'(bv_a), 1);
    chk("drain_byte", 32'(bo_a), 'h83);
    #2 reset = 1'b1;
    #1;
    chk("arst_byte_valid", 32'(bv_a), 0);
    chk("arst_byte_out", 32'(bo_a), 0);
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_done", 32'(done_a), 0);
    chk("arst_byte_count", 32'(bc_a), 0);
    chk("arst_pixel_ready", 32'(pr_a), 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    hold = 1'b0;
    make_random_frame(4);
    encode_frame(1, 2);

    // Randomized frames on every frame size
    for (int i = 0; i < NI; i++) begin
      act = i;
      for (int f = 0; f < 5; f++) begin
        make_random_frame(frame_len(i));
        encode_frame((f == 0) ? 0 : 1, $urandom_range(0, 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
